// File: rtl/regfile_write_ctrl_pkg.sv
// Shared types and constants for the register-file write controller.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef enum logic {
    RFC_CLEAR,
    RFC_RUN
  } rfc_state_t;

  // One register-file write-port transaction.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] wn;
    logic [DATA_W-1:0] wd;
  } rf_wr_t;

endpackage

// File: rtl/regfile_write_ctrl_if.sv
// Writeback requester handshakes plus the register-file write port.
interface regfile_write_ctrl_if;
  import regfile_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_wn;
  logic [DATA_W-1:0] req0_wd;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_wn;
  logic [DATA_W-1:0] req1_wd;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_wn;
  logic [DATA_W-1:0] rf_wd;
  logic              init_done;
  logic              zero_drop;

  // Requesters and register-file side.
  modport master (
    output req0_valid, req0_wn, req0_wd,
    output req1_valid, req1_wn, req1_wd,
    input  req0_ready, req1_ready,
    input  rf_we, rf_wn, rf_wd, init_done, zero_drop
  );

  // The write controller.
  modport slave (
    input  req0_valid, req0_wn, req0_wd,
    input  req1_valid, req1_wn, req1_wd,
    output req0_ready, req1_ready,
    output rf_we, rf_wn, rf_wd, init_done, zero_drop
  );
endinterface

// File: rtl/regfile_write_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the requester granted last loses a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic rr_last_reg;

  // Each requester wins when alone, or on contention when it was not the last winner.
  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    assign grant[gi] = valid[gi] & (~valid[1-gi] | (rr_last_reg != 1'(gi)));
  end

  // Remember the most recent winner; reset favours requester 0 on first contention.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_last_reg <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      rr_last_reg <= grant[1];
    end
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write sequencer: zero sweep after reset, then arbitrated writeback.
import regfile_pkg::*;

module regfile_write_ctrl #(
  parameter int NUM_REGS       = regfile_pkg::NUM_REGS,
  parameter int ADDR_W         = regfile_pkg::ADDR_W,
  parameter int DATA_W         = regfile_pkg::DATA_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  regfile_write_ctrl_if.slave bus
);

  localparam logic [ADDR_W:0] LAST_IDX   = (ADDR_W+1)'(NUM_REGS - 1);
  localparam rfc_state_t      RESET_STATE = CLEAR_ON_RESET ? RFC_CLEAR : RFC_RUN;

  rfc_state_t      state_reg, state_next;
  logic [ADDR_W:0] clr_idx_reg, clr_idx_next;
  rf_wr_t          wr_reg, wr_next;
  logic            init_done_reg, init_done_next;
  logic            zero_drop_reg, zero_drop_next;
  logic            run;
  logic [1:0]      grant;

  // Requests are only visible to the arbiter in RUN and outside reset, so no
  // ready is ever shown for a write that reset would discard.
  assign run = (state_reg == RFC_RUN) && rst;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   ({bus.req1_valid, bus.req0_valid} & {2{run}}),
    .advance (run),
    .grant   (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.rf_we      = wr_reg.we;
  assign bus.rf_wn      = wr_reg.wn;
  assign bus.rf_wd      = wr_reg.wd;
  assign bus.init_done  = init_done_reg;
  assign bus.zero_drop  = zero_drop_reg;

  // State register and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= RESET_STATE;
      clr_idx_reg   <= '0;
      wr_reg        <= '0;
      init_done_reg <= 1'b0;
      zero_drop_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      clr_idx_reg   <= clr_idx_next;
      wr_reg        <= wr_next;
      init_done_reg <= init_done_next;
      zero_drop_reg <= zero_drop_next;
    end
  end

  // Next-state and write-port selection; address/data hold when idle.
  always_comb begin
    state_next     = state_reg;
    clr_idx_next   = clr_idx_reg;
    wr_next        = '{we: 1'b0, wn: wr_reg.wn, wd: wr_reg.wd};
    init_done_next = init_done_reg;
    zero_drop_next = 1'b0;
    case (state_reg)
      RFC_CLEAR: begin
        wr_next      = '{we: 1'b1, wn: clr_idx_reg[ADDR_W-1:0], wd: {DATA_W{1'b0}}};
        clr_idx_next = clr_idx_reg + 1'b1;
        if (clr_idx_reg == LAST_IDX) begin
          state_next     = RFC_RUN;
          init_done_next = 1'b1;
        end
      end
      RFC_RUN: begin
        init_done_next = 1'b1;
        if (grant != 2'b00) begin
          if (grant[1]) begin
            wr_next = '{we: 1'b1, wn: bus.req1_wn, wd: bus.req1_wd};
          end else begin
            wr_next = '{we: 1'b1, wn: bus.req0_wn, wd: bus.req0_wd};
          end
          // Register 0 is hardwired: accept the handshake but suppress the write.
          if (wr_next.wn == '0) begin
            wr_next.we     = 1'b0;
            zero_drop_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = RESET_STATE;
      end
    endcase
  end

endmodule
